serial_receiver: RTL

//   Receive half of the 8N1 serial link, clocked at 100 MHz. Takes the async line din,

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_receiver_tick_gen.sv | 23 ++
 rtl/serial_receiver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared bit-timing arithmetic and receive FSM encoding for the 8N1 serial link.
// The transmitter derives its bit timing from the same formula, so both ends agree.
package serial_pkg;

    localparam int CLK_FREQ_DEF     = 100_000_000;
    localparam int BAUD_RATE_DEF    = 9600;
    localparam int SAMPLE_RATIO_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    function automatic int calc_sample_div(input int clk_freq, input int baud, input int ratio);
        return clk_freq / baud / ratio;
    endfunction

    localparam int SAMPLE_DIV_DEF = calc_sample_div(CLK_FREQ_DEF, BAUD_RATE_DEF, SAMPLE_RATIO_DEF);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_receiver_tick_gen.sv
// Oversample enable: a free-running divider that pulses tick for one clk on wrap.
module sample_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_receiver.sv
// 8N1 receive path: 2-FF synchroniser, 16x oversampled 3-sample majority vote,
// frame FSM and a valid/ready output register with overrun/frame-error pulses.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLK_FREQ     = CLK_FREQ_DEF,
    parameter int BAUD_RATE    = BAUD_RATE_DEF,
    parameter int SAMPLE_RATIO = SAMPLE_RATIO_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int SAMPLE_DIV = calc_sample_div(CLK_FREQ, BAUD_RATE, SAMPLE_RATIO);
    localparam int SCW        = $clog2(SAMPLE_RATIO);
    localparam int BIW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SCW-1:0] SC_LO   = SCW'(SAMPLE_RATIO / 2 - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(SAMPLE_RATIO / 2);
    localparam logic [SCW-1:0] SC_HI   = SCW'(SAMPLE_RATIO / 2 + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SAMPLE_RATIO - 1);
    localparam logic [BIW-1:0] BIT_LAST = BIW'(DATA_BITS - 1);

    logic                 tick;
    logic [1:0]           sync_q, sync_d;
    logic                 rxd;
    rx_state_e            state_q, state_d;
    logic [SCW-1:0]       sc_q, sc_d;
    logic [BIW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 vote;
    logic                 byte_done;

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign rxd  = sync_q[1];
    assign vote = maj3(samp_q[0], samp_q[1], rxd);

    always_comb begin
        sync_d      = {sync_q[0], din};
        state_d     = state_q;
        sc_d        = sc_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        samp_d      = samp_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            if (state_q == START || state_q == DATA || state_q == STOP) begin
                sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SCW'(1);
                if (sc_q == SC_LO)  samp_d[0] = rxd;
                if (sc_q == SC_MID) samp_d[1] = rxd;
            end

            case (state_q)
                IDLE: begin
                    if (!rxd) begin
                        state_d = START;
                        sc_d    = '0;
                    end
                end
                START: begin
                    if (sc_q == SC_HI && vote) begin
                        state_d = IDLE;
                    end else if (sc_q == SC_LAST) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    // LSB is on the wire first, so shifting in at the MSB leaves it at bit 0
                    if (sc_q == SC_HI) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (sc_q == SC_LAST) begin
                        if (bit_q == BIT_LAST) state_d = STOP;
                        else                   bit_d   = bit_q + BIW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a slightly fast sender's next start edge is caught
                    if (sc_q == SC_HI) begin
                        if (vote) begin
                            byte_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rxd) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q & ~dout_ready;
        overrun_d    = 1'b0;
        if (byte_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shreg_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            samp_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            samp_q       <= samp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
